// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use hazard detection for an in-order pipeline.
// It tracks loads that have left ID/EX and whose results are still
// outstanding, and stalls the IF/ID instruction when it reads one of them.
// It also stalls a new load when no scoreboard entry would be left for it.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_rs1/2, id_rs1/2_used     IF/ID source registers and their use flags
//   id_mem_read                 IF/ID instruction is a load
//   ex_valid, ex_rd, ex_mem_read ID/EX occupancy, destination, load flag
//   mem_ready                   memory progressed this cycle (countdown enable)
//   flush                       branch redirect, kills IF/ID and ID/EX
//   stall, pc_write, if_id_write, id_ex_bubble   combinational pipeline control
//   busy_cnt                    occupied scoreboard entries
//   stall_cycles                saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_mem_read,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              mem_ready,
    input  logic              flush,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic [3:0]        busy_cnt,
    output logic [15:0]       stall_cycles
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BUSY_W = 4;
    localparam int unsigned SUM_W  = 5;
    localparam int unsigned SC_W   = 16;

    // Scoreboard state
    logic [DEPTH-1:0]  r_valid;
    logic [REG_AW-1:0] r_rd  [DEPTH];
    logic [CNT_W-1:0]  r_cnt [DEPTH];
    logic [BUSY_W-1:0] r_busy_cnt;
    logic [SC_W-1:0]   r_stall_cycles;

    // Next-state and hazard terms
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [REG_AW-1:0] w_rd_nxt  [DEPTH];
    logic [CNT_W-1:0]  w_cnt_nxt [DEPTH];
    logic [BUSY_W-1:0] w_busy_nxt;
    logic              w_alloc_done;
    logic              w_ex_load;
    logic              w_alloc_req;
    logic              w_rs1_live;
    logic              w_rs2_live;
    logic              w_hit_ex;
    logic              w_hit_sb;
    logic              w_full;
    logic              w_stall;

    // Source operands that can actually carry a hazard (x0 never does)
    assign w_rs1_live  = id_rs1_used & (id_rs1 != '0);
    assign w_rs2_live  = id_rs2_used & (id_rs2 != '0);
    assign w_ex_load   = ex_valid & ex_mem_read & (ex_rd != '0);
    assign w_alloc_req = w_ex_load & ~flush;

    // Load in ID/EX feeding the IF/ID instruction
    assign w_hit_ex = w_ex_load & ((w_rs1_live & (id_rs1 == ex_rd)) |
                                   (w_rs2_live & (id_rs2 == ex_rd)));

    // Any outstanding load (duplicates allowed) feeding the IF/ID instruction
    always_comb begin
        w_hit_sb = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && ((w_rs1_live && (id_rs1 == r_rd[i])) ||
                               (w_rs2_live && (id_rs2 == r_rd[i])))) begin
                w_hit_sb = 1'b1;
            end
        end
    end

    // A new load must wait when the load ahead of it would take the last entry
    assign w_full = id_mem_read &
                    ((SUM_W'(r_busy_cnt) + SUM_W'(w_ex_load)) >= SUM_W'(DEPTH));

    assign w_stall      = ~flush & (w_hit_ex | w_hit_sb | w_full);
    assign stall        = w_stall;
    assign pc_write     = ~w_stall;
    assign if_id_write  = ~w_stall;
    assign id_ex_bubble = w_stall | flush;
    assign busy_cnt     = r_busy_cnt;
    assign stall_cycles = r_stall_cycles;

    // Countdown/retire, then allocate into the lowest slot that was free
    // before this edge; a slot retiring now is not reused in the same cycle.
    // With every slot busy the allocation is silently dropped.
    always_comb begin
        w_valid_nxt  = r_valid;
        w_rd_nxt     = r_rd;
        w_cnt_nxt    = r_cnt;
        w_alloc_done = 1'b0;
        if (mem_ready) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i]) begin
                    w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                    if (r_cnt[i] == CNT_W'(1)) begin
                        w_valid_nxt[i] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alloc_req && !w_alloc_done && !r_valid[i]) begin
                w_valid_nxt[i] = 1'b1;
                w_rd_nxt[i]    = ex_rd;
                w_cnt_nxt[i]   = CNT_W'(MEM_LAT);
                w_alloc_done   = 1'b1;
            end
        end
    end

    // Occupancy of the next state, so busy_cnt tracks the valid bits exactly
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy_nxt = w_busy_nxt + BUSY_W'(w_valid_nxt[i]);
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_busy_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_valid    <= w_valid_nxt;
            r_busy_cnt <= w_busy_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]  <= w_rd_nxt[i];
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + SC_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic,
// all compared against a queue-based model of outstanding loads.
module tb_hazard_scoreboard;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned DEPTH   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_rs1_used, id_rs2_used, id_mem_read;
    logic              ex_valid, ex_mem_read, mem_ready, flush;
    logic              stall, pc_write, if_id_write, id_ex_bubble;
    logic [3:0]        busy_cnt;
    logic [15:0]       stall_cycles;

    hazard_scoreboard #(.REG_AW(REG_AW), .MEM_LAT(MEM_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_mem_read(id_mem_read),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_ready(mem_ready), .flush(flush),
        .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .busy_cnt(busy_cnt),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: an unordered bag of outstanding loads
    typedef struct {
        logic [REG_AW-1:0] rd;
        int                rem;
    } load_t;

    load_t q[$];
    int    m_sc;
    int    checks;
    int    errors;

    function automatic bit m_stall();
        bit ex_load;
        if (flush) return 1'b0;
        ex_load = ex_valid && ex_mem_read && (ex_rd != 0);
        if (ex_load && id_rs1_used && id_rs1 != 0 && id_rs1 == ex_rd) return 1'b1;
        if (ex_load && id_rs2_used && id_rs2 != 0 && id_rs2 == ex_rd) return 1'b1;
        foreach (q[i]) begin
            if (id_rs1_used && id_rs1 != 0 && id_rs1 == q[i].rd) return 1'b1;
            if (id_rs2_used && id_rs2 != 0 && id_rs2 == q[i].rd) return 1'b1;
        end
        if (id_mem_read && (q.size() + int'(ex_load)) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one rising edge using the inputs present at it
    task automatic mdl_edge();
        bit    st;
        bit    al;
        load_t keep[$];
        st = m_stall();
        al = !flush && ex_valid && ex_mem_read && (ex_rd != 0) && (q.size() < DEPTH);
        if (st && m_sc < 65535) m_sc++;
        if (mem_ready) begin
            foreach (q[i]) begin
                if (q[i].rem > 1) keep.push_back('{q[i].rd, q[i].rem - 1});
            end
            q = keep;
        end
        if (al) q.push_back('{ex_rd, MEM_LAT});
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        bit es;
        es = m_stall();
        check("stall", 32'(stall), 32'(es));
        check("pc_write", 32'(pc_write), 32'(!es));
        check("if_id_write", 32'(if_id_write), 32'(!es));
        check("id_ex_bubble", 32'(id_ex_bubble), 32'(es || flush));
        check("busy_cnt", 32'(busy_cnt), 32'(q.size()));
        check("stall_cycles", 32'(stall_cycles), 32'(m_sc));
    endtask

    // One clock: check at mid-low phase, take the edge, return at negedge
    task automatic cyc(input bit do_chk);
        #1;
        if (do_chk) chk_all();
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_mem_read = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_mem_read = 1'b0;
        mem_ready = 1'b1; flush = 1'b0;
    endtask

    task automatic set_load(input logic [REG_AW-1:0] rd);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd;
    endtask

    // Reset pulse spanning one rising edge, checked while asserted
    task automatic do_reset();
        #2 rst_n = 1'b0;
        q.delete();
        m_sc = 0;
        #1;
        check("rst_busy", 32'(busy_cnt), 32'd0);
        check("rst_sc", 32'(stall_cycles), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_sc   = 0;
        rst_n  = 1'b0;
        idle();
        @(negedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_pc_write", 32'(pc_write), 32'd1);
        check("reset_if_id_write", 32'(if_id_write), 32'd1);
        check("reset_bubble", 32'(id_ex_bubble), 32'd0);
        check("reset_busy", 32'(busy_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        // Load-use against the load in ID/EX
        set_load(5'd5);
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        #1;
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_bubble", 32'(id_ex_bubble), 32'd1);
        id_rs1 = 5'd6;
        #1;
        check("lu_nohit", 32'(stall), 32'd0);
        cyc(1);
        idle();
        repeat (3) cyc(1);

        // Countdown with memory always ready
        set_load(5'd7);
        cyc(1);
        idle();
        id_rs2 = 5'd7; id_rs2_used = 1'b1;
        #1;
        check("cd_e0_stall", 32'(stall), 32'd1);
        check("cd_e0_busy", 32'(busy_cnt), 32'd1);
        cyc(1);
        check("cd_e1_stall", 32'(stall), 32'd1);
        check("cd_e1_busy", 32'(busy_cnt), 32'd1);
        cyc(1);
        check("cd_e2_stall", 32'(stall), 32'd0);
        check("cd_e2_busy", 32'(busy_cnt), 32'd0);

        // Memory wait freezes the countdown
        idle();
        set_load(5'd7);
        cyc(1);
        idle();
        id_rs2 = 5'd7; id_rs2_used = 1'b1; mem_ready = 1'b0;
        repeat (3) cyc(1);
        check("mw_held_stall", 32'(stall), 32'd1);
        check("mw_held_busy", 32'(busy_cnt), 32'd1);
        mem_ready = 1'b1;
        cyc(1);
        check("mw_one_left", 32'(stall), 32'd1);
        cyc(1);
        check("mw_freed_stall", 32'(stall), 32'd0);
        check("mw_freed_busy", 32'(busy_cnt), 32'd0);

        // Full scoreboard holds back a new load
        idle();
        mem_ready = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            set_load(REG_AW'(r));
            cyc(1);
        end
        set_load(5'd4);
        id_mem_read = 1'b1; id_rs1 = 5'd10; id_rs1_used = 1'b1;
        #1;
        check("full_pending", 32'(stall), 32'd1);
        cyc(1);
        set_load(5'd0);
        #1;
        check("full_busy4", 32'(busy_cnt), 32'd4);
        check("full_stall", 32'(stall), 32'd1);
        cyc(1);
        check("full_x0_noalloc", 32'(busy_cnt), 32'd4);
        ex_valid = 1'b0;
        mem_ready = 1'b1;
        cyc(1);
        cyc(1);
        check("full_drained_stall", 32'(stall), 32'd0);
        check("full_drained_busy", 32'(busy_cnt), 32'd0);

        // Flush masks the hazard and blocks allocation; x0 never hazards
        idle();
        flush = 1'b1;
        set_load(5'd5);
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        #1;
        check("fl_stall", 32'(stall), 32'd0);
        check("fl_bubble", 32'(id_ex_bubble), 32'd1);
        cyc(1);
        check("fl_noalloc", 32'(busy_cnt), 32'd0);
        flush = 1'b0;
        set_load(5'd0);
        id_rs1 = 5'd0;
        #1;
        check("x0_stall", 32'(stall), 32'd0);
        cyc(1);
        check("x0_noalloc", 32'(busy_cnt), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            id_rs1      = REG_AW'($urandom_range(0, 7));
            id_rs2      = REG_AW'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_mem_read = ($urandom_range(0, 3) == 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_rd       = REG_AW'($urandom_range(0, 7));
            mem_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 9) == 0);
            cyc(1);
        end

        // Reset in the middle of activity
        idle();
        do_reset();
        mem_ready = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            set_load(REG_AW'(r));
            cyc(1);
        end
        idle();
        mem_ready = 1'b0;
        id_rs1 = 5'd1; id_rs1_used = 1'b1;
        repeat (10) cyc(1);
        #1;
        check("mid_sc10", 32'(stall_cycles), 32'd10);
        check("mid_busy3", 32'(busy_cnt), 32'd3);
        do_reset();
        cyc(1);

        // Saturation of the stall-cycle counter
        idle();
        set_load(5'd9);
        cyc(1);
        idle();
        mem_ready = 1'b0;
        id_rs1 = 5'd9; id_rs1_used = 1'b1;
        for (int n = 0; n < 70000; n++) cyc(1'b0);
        cyc(1);
        check("sat_sc", 32'(stall_cycles), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-index width (2**REG_AW architectural registers).
REQ-002 SHALL have parameter MEM_LAT, default 2, range 1-15: cycles a load's result stays pending after leaving ID/EX.
REQ-003 SHALL have parameter DEPTH, default 4, range 1-8: scoreboard entries (outstanding loads).
REQ-004 SHALL have the following ports, one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- id_rs1, id_rs2  in  REG_AW each  source registers of the IF/ID instruction.
- id_rs1_used, id_rs2_used  in  1 each  source actually read.
- id_mem_read  in  1  IF/ID instruction is a load.
- ex_valid  in  1  ID/EX holds a real instruction (not a bubble).
- ex_rd  in  REG_AW  ID/EX destination register.
- ex_mem_read  in  1  ID/EX instruction is a load.
- mem_ready  in  1  memory accepted/returned data this cycle; low freezes countdown.
- flush  in  1  branch redirect; kills IF/ID and ID/EX.
- stall  out  1  hold PC and IF/ID, insert bubble.
- pc_write, if_id_write  out  1 each  equal to ~stall.
- id_ex_bubble  out  1  zero ID/EX controls next edge (stall | flush).
- busy_cnt  out  4  occupied scoreboard entries.
- stall_cycles  out  16  saturating count of stalled cycles.

Function
REQ-005 SHALL hold per entry: valid bit, rd (REG_AW), countdown (4 bits).
REQ-006 SHALL allocate, at a rising edge where ex_valid & ex_mem_read & (ex_rd != 0) & ~flush, the lowest-index entry free before that edge, with rd = ex_rd, countdown = MEM_LAT.
REQ-007 SHALL decrement every valid entry's countdown at each edge with mem_ready = 1; countdown held when mem_ready = 0.
REQ-008 SHALL clear an entry's valid bit at the edge its countdown goes 1 -> 0; such an entry is not free for allocation at that same edge.
REQ-009 SHALL assert stall combinationally when ~flush and either: (a) id_rsN_used, id_rsN != 0, ex_valid, ex_mem_read, id_rsN == ex_rd, for N = 1 or 2; or (b) id_rsN_used, id_rsN != 0, id_rsN matches rd of any valid entry; or (c) id_mem_read and busy_cnt + (ex_valid & ex_mem_read & ex_rd != 0) >= DEPTH.
REQ-010 SHALL treat register 0 as never hazardous for sources and never allocate it.
REQ-011 SHALL allow duplicate rd entries; a match against any of them stalls.
REQ-012 SHALL force stall = 0 and id_ex_bubble = 1 while flush = 1; flush does not clear already-allocated entries.
REQ-013 SHALL, if the allocation condition holds with no free entry (protocol violation), drop the allocation and keep state unchanged.
REQ-014 SHALL drive busy_cnt as the popcount of valid bits, registered state only.
REQ-015 SHALL increment stall_cycles at each edge where stall = 1, saturating at 16'hFFFF.
REQ-016 SHALL have zero-cycle latency from inputs to stall/pc_write/if_id_write/id_ex_bubble; all state updates on rising clk.

Reset
REQ-017 SHALL, while rst_n = 0, asynchronously clear all valid bits, countdowns, rd fields and stall_cycles; busy_cnt = 0.
REQ-018 SHALL, during and after reset with idle inputs, drive stall = 0, pc_write = 1, if_id_write = 1, id_ex_bubble = 0.
REQ-019 SHALL, on reset assertion mid-operation, drop every pending load; first cycle after release behaves as empty scoreboard.

Verification
REQ-020 Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5; id_rs1=5, id_rs1_used=1 -> stall=1, pc_write=0, id_ex_bubble=1 same cycle; id_rs1=6 -> stall=0.
REQ-021 Countdown, MEM_LAT=2, mem_ready=1: load rd=7 leaves EX at edge 0 -> id_rs2=7 stalls after edges 0 and 1, not after edge 2; busy_cnt 1,1,0.
REQ-022 Memory wait: as REQ-021 with mem_ready=0 for 3 cycles after edge 0 -> stall held 3 extra cycles; entry frees 2 ready edges later.
REQ-023 Full, DEPTH=4: four loads rd=1..4 allocated, id_mem_read=1, id sources unrelated -> stall=1 until one entry frees; fifth load with ex_rd=0 never allocates.
REQ-024 Flush and x0: flush=1 with matching rd=5 -> stall=0, id_ex_bubble=1, no allocation; id_rs1=0 against load rd=0 -> stall=0.
REQ-025 Reset mid-run: three entries valid, stall_cycles=10, rst_n low for one cycle -> busy_cnt=0, stall_cycles=0, stall=0 immediately; stall_cycles saturates at 16'hFFFF under 70000 forced stall cycles.
